// File: rtl/counter_run_ctrl_if.sv
// Command/config and status bundle between a controller source and counter_run_ctrl.
// master drives commands and config; slave is the run controller.
interface counter_run_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) ();
    logic              start;
    logic              stop;
    logic              pause;
    logic [WIDTH-1:0]  cfg_load;
    logic [WIDTH-1:0]  cfg_limit;
    logic              cfg_auto;
    logic [WIDTH-1:0]  out;
    logic              busy;
    logic              done;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [1:0]        state;

    modport master (
        output start, stop, pause, cfg_load, cfg_limit, cfg_auto,
        input  out, busy, done, wrap_cnt, state
    );

    modport slave (
        input  start, stop, pause, cfg_load, cfg_limit, cfg_auto,
        output out, busy, done, wrap_cnt, state
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run controller owning the up counter: start/pause/stop, one-shot or auto-reload
// against a shadowed load/limit pair, with registered done pulse and wrap count.
module counter_run_ctrl #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    counter_run_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]        state_reg, state_next;
    logic [WIDTH-1:0]  out_reg, out_next;
    logic              done_reg, done_next;
    logic [WRAP_W-1:0] wrap_reg, wrap_next;
    logic [WIDTH-1:0]  load_reg, load_next;
    logic [WIDTH-1:0]  limit_reg, limit_next;
    logic              auto_reg, auto_next;

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        done_next  = 1'b0;
        wrap_next  = wrap_reg;
        load_next  = load_reg;
        limit_next = limit_reg;
        auto_next  = auto_reg;
        if (bus.stop) begin
            // wrap count is deliberately kept so it can be read back after stop
            state_next = ST_IDLE;
            out_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_next = ST_RUN;
                        out_next   = bus.cfg_load;
                        wrap_next  = '0;
                        load_next  = bus.cfg_load;
                        limit_next = bus.cfg_limit;
                        auto_next  = bus.cfg_auto;
                    end
                end
                ST_RUN: begin
                    // pause wins over a terminal match; the match is re-evaluated after resume
                    if (bus.pause) begin
                        state_next = ST_PAUSED;
                    end else if (out_reg == limit_reg) begin
                        done_next = 1'b1;
                        if (auto_reg) begin
                            out_next = load_reg;
                            if (wrap_reg != {WRAP_W{1'b1}}) begin
                                wrap_next = wrap_reg + WRAP_W'(1);
                            end
                        end else begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        out_next = out_reg + WIDTH'(1);
                    end
                end
                ST_PAUSED: begin
                    if (!bus.pause) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            out_reg   <= '0;
            done_reg  <= 1'b0;
            wrap_reg  <= '0;
            load_reg  <= '0;
            limit_reg <= '0;
            auto_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
            wrap_reg  <= wrap_next;
            load_reg  <= load_next;
            limit_reg <= limit_next;
            auto_reg  <= auto_next;
        end
    end

    assign bus.out      = out_reg;
    assign bus.state    = state_reg;
    assign bus.done     = done_reg;
    assign bus.wrap_cnt = wrap_reg;
    assign bus.busy     = (state_reg == ST_RUN) || (state_reg == ST_PAUSED);
endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl: reset, one-shot, auto-reload, pause/stop,
// ignored commands, saturation and asynchronous reset, with hand-computed expectations.
module tb_counter_run_ctrl;
    localparam int W  = 4;
    localparam int WW = 8;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    counter_run_ctrl_if #(.WIDTH(W), .WRAP_W(WW)) bus ();

    counter_run_ctrl #(.WIDTH(W), .WRAP_W(WW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("chk %-10s obs=%0d exp=%0d", tag, obs, exp);
    endtask

    // out/state/busy/done in one go; busy follows from the expected state
    task automatic chk(input string tag, input int eo, input int es, input int ed);
        check({tag, ".out"},   32'(bus.out),   32'(eo));
        check({tag, ".state"}, 32'(bus.state), 32'(es));
        check({tag, ".busy"},  32'(bus.busy),  ((es == 1) || (es == 2)) ? 32'd1 : 32'd0);
        check({tag, ".done"},  32'(bus.done),  32'(ed));
    endtask

    logic [3:0] seq [4];

    initial begin
        total = 0;
        bad   = 0;
        seq[0] = 4'd14; seq[1] = 4'd15; seq[2] = 4'd0; seq[3] = 4'd1;
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        bus.cfg_load = '0; bus.cfg_limit = '0; bus.cfg_auto = 0;
        rstn = 1'b0;

        // reset and idle
        #12;
        chk("rst", 0, 0, 0);
        check("rst.wrap", 32'(bus.wrap_cnt), 0);
        #8 rstn = 1'b1;
        repeat (10) begin
            tick();
            chk("idle", 0, 0, 0);
        end

        // one-shot 0..3
        bus.cfg_load = 4'd0; bus.cfg_limit = 4'd3; bus.cfg_auto = 0; bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k < 4; k++) begin
            chk("oneshot", k, 1, 0);
            tick();
        end
        chk("os_done", 3, 3, 1);
        tick();
        chk("os_hold", 3, 3, 0);

        // auto-reload through 15 -> 0
        bus.cfg_load = 4'd14; bus.cfg_limit = 4'd1; bus.cfg_auto = 1; bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 1; k <= 13; k++) begin
            chk("auto", int'(seq[(k-1)%4]), 1, (k > 1 && (k-1)%4 == 0) ? 1 : 0);
            check("auto.wrap", 32'(bus.wrap_cnt), 32'((k-1)/4));
            if (k < 13) tick();
        end
        bus.stop = 1;
        tick();
        bus.stop = 0;
        chk("auto_stop", 0, 0, 0);
        check("stop.wrap", 32'(bus.wrap_cnt), 3);

        // limit == load: done every cycle, wrap count saturates
        bus.cfg_load = 4'd5; bus.cfg_limit = 4'd5; bus.cfg_auto = 1; bus.start = 1;
        tick();
        bus.start = 0;
        chk("eq_c1", 5, 1, 0);
        check("eq_c1.wrap", 32'(bus.wrap_cnt), 0);
        tick();
        chk("eq_c2", 5, 1, 1);
        check("eq_c2.wrap", 32'(bus.wrap_cnt), 1);
        tick();
        chk("eq_c3", 5, 1, 1);
        check("eq_c3.wrap", 32'(bus.wrap_cnt), 2);
        repeat (300) tick();
        chk("sat", 5, 1, 1);
        check("sat.wrap", 32'(bus.wrap_cnt), 255);
        bus.stop = 1;
        tick();
        bus.stop = 0;
        chk("sat_stop", 0, 0, 0);
        check("sat_stop.wrap", 32'(bus.wrap_cnt), 255);

        // pause, ignored restart, stop
        bus.cfg_load = 4'd2; bus.cfg_limit = 4'd9; bus.cfg_auto = 0; bus.start = 1;
        tick();
        bus.start = 0;
        chk("ps_c1", 2, 1, 0);
        check("ps_c1.wrap", 32'(bus.wrap_cnt), 0);
        repeat (3) tick();
        chk("ps_at5", 5, 1, 0);
        bus.pause = 1;
        repeat (3) begin
            tick();
            chk("paused", 5, 2, 0);
        end
        bus.pause = 0;
        tick();
        chk("resume", 5, 1, 0);
        tick();
        chk("resume+1", 6, 1, 0);
        bus.start = 1; bus.cfg_load = 4'd8;
        tick();
        bus.start = 0;
        chk("ign_start", 7, 1, 0);
        bus.stop = 1;
        tick();
        bus.stop = 0;
        chk("ps_stop", 0, 0, 0);
        tick();
        chk("ps_idle", 0, 0, 0);

        // terminal coinciding with pause is deferred
        bus.cfg_load = 4'd0; bus.cfg_limit = 4'd1; bus.cfg_auto = 0; bus.start = 1;
        tick();
        bus.start = 0;
        chk("df_c1", 0, 1, 0);
        tick();
        chk("df_c2", 1, 1, 0);
        bus.pause = 1;
        tick();
        chk("df_pause", 1, 2, 0);
        bus.pause = 0;
        tick();
        chk("df_resume", 1, 1, 0);
        tick();
        chk("df_done", 1, 3, 1);

        // stop + start together keeps IDLE
        bus.stop = 1;
        tick();
        chk("to_idle", 0, 0, 0);
        bus.start = 1;
        tick();
        bus.stop = 0; bus.start = 0;
        chk("stop_start", 0, 0, 0);
        tick();
        chk("stop_start2", 0, 0, 0);

        // asynchronous reset between edges
        bus.cfg_load = 4'd0; bus.cfg_limit = 4'd9; bus.cfg_auto = 0; bus.start = 1;
        tick();
        bus.start = 0;
        repeat (6) tick();
        chk("ar_at6", 6, 1, 0);
        #2 rstn = 1'b0;
        #1;
        chk("ar_async", 0, 0, 0);
        check("ar.wrap", 32'(bus.wrap_cnt), 0);
        #2 rstn = 1'b1;
        bus.cfg_load = 4'd0; bus.cfg_limit = 4'd3; bus.cfg_auto = 0; bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k < 4; k++) begin
            chk("ar_os", k, 1, 0);
            tick();
        end
        chk("ar_done", 3, 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
